seal_trace_buffer: RTL and testbench

- Memory-mapped bus device (responder) on the simple-system bus; captures 32-bit leakage samples into an on-chip FIFO.
- Samples come from the core-side probe point: write-back value, ALU result, or memory data, selected by the integrator.
- Software running on Ibex arms the block, then drains samples through a DATA register.
- Provides the inverse path to DPI trace export: data flows back to software over the bus instead of out to the host simulator.

---
 rtl/seal_trace_pkg.sv | 16 +
 rtl/seal_trace_fifo.sv | 51 +++++
 rtl/seal_trace_buffer.sv | 121 ++++++++++++
 tb/tb_seal_trace_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seal_trace_pkg.sv
// Shared constants for the trace buffer: register byte offsets and bit positions.
package seal_trace_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_DATA   = 8'h08;
  localparam logic [7:0] OFF_THRESH = 8'h0C;

  localparam int ST_EMPTY = 16;
  localparam int ST_FULL  = 17;
  localparam int ST_OVF   = 18;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

endpackage

// File: rtl/seal_trace_fifo.sv
// Single-clock FIFO with combinational head read; clear beats push and pop.
module seal_trace_fifo #(
  parameter int Depth = 64,
  parameter int Width = 32,
  parameter int CntW  = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/seal_trace_buffer.sv
// Bus-mapped capture buffer: probe samples into a FIFO, drained by software via DATA.
module seal_trace_buffer
  import seal_trace_pkg::*;
#(
  parameter int Depth    = 64,
  parameter int AddrBits = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        sample_valid_i,
  input  logic [31:0] sample_data_i,
  output logic        irq_o
);

  localparam int CntW = $clog2(Depth) + 1;

  logic [AddrBits-1:0] off;
  logic [31:0]         fifo_rdata, rdata_d, rdata_q;
  logic [CntW-1:0]     count, thresh_d, thresh_q;
  logic                full, empty;
  logic                push, pop, clr, w1c, ovf_set;
  logic                en_d, en_q, err_d, err_q, rvalid_q, ovf_q, irq_d, irq_q;
  logic                unused_bits;

  // Byte lanes and out-of-window address bits carry no meaning here.
  assign unused_bits = ^{be_i, addr_i, wdata_i};
  assign off = {addr_i[AddrBits-1:2], 2'b00};

  seal_trace_fifo #(.Depth(Depth), .Width(32), .CntW(CntW)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .clr_i   (clr),
    .wdata_i (sample_data_i),
    .rdata_o (fifo_rdata),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    rdata_d  = '0;
    err_d    = 1'b0;
    pop      = 1'b0;
    clr      = 1'b0;
    w1c      = 1'b0;
    en_d     = en_q;
    thresh_d = thresh_q;
    if (req_i) begin
      if (off == AddrBits'(OFF_CTRL)) begin
        if (we_i) begin
          en_d = wdata_i[CTRL_EN];
          clr  = wdata_i[CTRL_CLR];
        end else begin
          rdata_d[CTRL_EN] = en_q;
        end
      end else if (off == AddrBits'(OFF_STATUS)) begin
        if (we_i) begin
          w1c = wdata_i[ST_OVF];
        end else begin
          rdata_d[CntW-1:0] = count;
          rdata_d[ST_EMPTY] = empty;
          rdata_d[ST_FULL]  = full;
          rdata_d[ST_OVF]   = ovf_q;
        end
      end else if (off == AddrBits'(OFF_DATA)) begin
        if (we_i || empty) begin
          err_d = 1'b1;
        end else begin
          pop     = 1'b1;
          rdata_d = fifo_rdata;
        end
      end else if (off == AddrBits'(OFF_THRESH)) begin
        if (we_i) thresh_d = wdata_i[CntW-1:0];
        else      rdata_d[CntW-1:0] = thresh_q;
      end else begin
        err_d = 1'b1;
      end
    end
    push    = sample_valid_i && en_q && (!full || pop);
    ovf_set = sample_valid_i && en_q && full && !pop;
    irq_d   = (en_q && (thresh_q != '0) && (count >= thresh_q)) || ovf_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      thresh_q <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      en_q     <= en_d;
      thresh_q <= thresh_d;
      // A fresh overflow outranks a same-cycle clear so no drop goes unreported.
      if (ovf_set)  ovf_q <= 1'b1;
      else if (w1c) ovf_q <= 1'b0;
      irq_q    <= irq_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_seal_trace_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_seal_trace_buffer;

  localparam int DEPTH = 64;
  localparam int CNTW  = 7;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        sample_valid_i = 1'b0;
  logic [31:0] sample_data_i = '0;
  logic        rvalid_o, err_o, irq_o;
  logic [31:0] rdata_o;

  always #5 clk_i = ~clk_i;

  seal_trace_buffer #(.Depth(DEPTH), .AddrBits(10)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .we_i           (we_i),
    .be_i           (be_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .err_o          (err_o),
    .sample_valid_i (sample_valid_i),
    .sample_data_i  (sample_data_i),
    .irq_o          (irq_o)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference state
  logic [31:0] q[$];
  bit          m_en, m_ovf;
  int          m_thr;
  bit          e_rv, e_err, e_irq;
  logic [31:0] e_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit req, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input bit sv, input logic [31:0] sd);
    int  n;
    bit  full, pop, clr, w1c, set_ovf, push, nirq, nen;
    logic [31:0] rd;
    bit  err;
    int  off;
    if (rst) begin
      q.delete();
      m_en = 0; m_ovf = 0; m_thr = 0;
      e_rv = 0; e_rd = 0; e_err = 0; e_irq = 0;
      return;
    end
    n    = q.size();
    full = (n == DEPTH);
    nirq = (m_en && m_thr != 0 && n >= m_thr) || m_ovf;
    pop = 0; clr = 0; w1c = 0; rd = 0; err = 0; nen = m_en;
    off = int'(a % 1024) / 4 * 4;
    if (req) begin
      case (off)
        0:  if (we) begin nen = wd[0]; clr = wd[1]; end else rd = 32'(m_en);
        4:  if (we) w1c = wd[18];
            else rd = 32'(n) + (n == 0 ? 32'h1_0000 : 0) + (full ? 32'h2_0000 : 0) + (m_ovf ? 32'h4_0000 : 0);
        8:  if (we || n == 0) err = 1; else begin rd = q[0]; pop = 1; end
        12: if (we) m_thr = int'(wd % (1 << CNTW)); else rd = 32'(m_thr);
        default: err = 1;
      endcase
    end
    push    = sv && m_en && (!full || pop);
    set_ovf = sv && m_en && full && !pop;
    if (pop) void'(q.pop_front());
    if (clr) q.delete();
    else if (push) q.push_back(sd);
    if (set_ovf) m_ovf = 1;
    else if (w1c) m_ovf = 0;
    m_en  = nen;
    e_rv  = req; e_rd = rd; e_err = err; e_irq = nirq;
  endtask

  task automatic step(input bit rst, input bit req, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input bit sv, input logic [31:0] sd);
    rst_i = rst; req_i = req; we_i = we; addr_i = a; wdata_i = wd;
    be_i = 4'($urandom); sample_valid_i = sv; sample_data_i = sd;
    model(rst, req, we, a, wd, sv, sd);
    @(posedge clk_i);
    #1;
    chk("rvalid", 32'(rvalid_o), 32'(e_rv));
    chk("rdata",  rdata_o, e_rd);
    chk("err",    32'(err_o), 32'(e_err));
    chk("irq",    32'(irq_o), 32'(e_irq));
  endtask

  task automatic rd(input logic [31:0] a);                    step(0, 1, 0, a, 0, 0, 0); endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d); step(0, 1, 1, a, d, 0, 0); endtask
  task automatic push(input logic [31:0] d);                   step(0, 0, 0, 0, 0, 1, d); endtask
  task automatic idle();                                        step(0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_irq", 32'(irq_o), 0);
    rd(32'h4);
    chk("reset_status", rdata_o, 32'h0001_0000);
    chk("reset_status_err", 32'(err_o), 0);
    rd(32'h8);
    chk("empty_data", rdata_o, 0);
    chk("empty_data_err", 32'(err_o), 1);

    wr(32'h0, 32'h1);
    for (int i = 1; i <= 3; i++) push(32'hA5A5_0000 + 32'(i));
    for (int i = 1; i <= 3; i++) begin
      rd(32'h8);
      chk("fifo_order", rdata_o, 32'hA5A5_0000 + 32'(i));
    end
    rd(32'h4);
    chk("drained_status", rdata_o, 32'h0001_0000);

    for (int i = 0; i < 65; i++) push(32'h1000 + 32'(i));
    idle();
    rd(32'h4);
    chk("full_status", rdata_o, 32'h0006_0040);
    chk("full_irq", 32'(irq_o), 1);
    wr(32'h4, 32'h0004_0000);
    idle();
    rd(32'h4);
    chk("ovf_w1c", rdata_o, 32'h0002_0040);

    step(0, 1, 0, 32'h8, 0, 1, 32'hDEAD_BEEF);
    chk("full_pushpop_head", rdata_o, 32'h1000);
    rd(32'h4);
    chk("full_pushpop_status", rdata_o, 32'h0002_0040);
    for (int i = 0; i < 64; i++) rd(32'h8);
    chk("last_drained", rdata_o, 32'hDEAD_BEEF);

    wr(32'hC, 32'd4);
    for (int i = 0; i < 3; i++) push(32'h2000 + 32'(i));
    idle();
    chk("thr_below", 32'(irq_o), 0);
    push(32'h2003);
    chk("thr_hit_same", 32'(irq_o), 0);
    idle();
    chk("thr_hit_next", 32'(irq_o), 1);
    rd(32'h8);
    idle();
    chk("thr_popped", 32'(irq_o), 0);

    step(0, 1, 1, 32'h0, 32'h3, 1, 32'h1234_5678);
    rd(32'h4);
    chk("clr_status", rdata_o, 32'h0001_0000);
    rd(32'h10);
    chk("bad_offset_err", 32'(err_o), 1);
    step(1, 1, 0, 32'h4, 0, 0, 0);
    chk("rst_drops_resp", 32'(rvalid_o), 0);
    idle();

    for (int blk = 0; blk < 6; blk++) begin
      int sv_pct = blk[0] ? 10 : 60;
      for (int c = 0; c < 500; c++) begin
        bit          r, w, sv, rs;
        logic [31:0] a, d;
        r  = $urandom_range(0, 99) < 40;
        w  = $urandom_range(0, 3) == 0;
        sv = $urandom_range(0, 99) < sv_pct;
        rs = $urandom_range(0, 499) == 0;
        d  = $urandom;
        case ($urandom_range(0, 9))
          0, 1:    a = 32'h0;
          2:       a = 32'h4;
          3, 4, 5: a = 32'h8;
          6, 7:    a = 32'hC;
          8:       a = 32'h10 + 32'($urandom_range(0, 250)) * 4;
          default: a = $urandom;
        endcase
        if (a[9:2] == 8'h0) begin
          d[0] = $urandom_range(0, 9) != 0;
          d[1] = $urandom_range(0, 29) == 0;
        end
        if (a[9:2] == 8'h3) d[6:0] = 7'($urandom_range(0, 70));
        a[1:0] = 2'($urandom);
        step(rs, r, w, a, d, sv, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
